// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl: turns CPU strobe edges into timed RAM cycles with wait
// states, a one-deep pending slot, reset-vector overlay and vector-page
// write protection.
module cpu_mem_ctrl #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] VEC_BASE    = 16'hFFF0,
  parameter logic [15:0] RESET_VEC   = 16'h1000
) (
  input  logic        cpu_clk,
  input  logic        cpu_reset,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_oe_i,
  input  logic        cpu_we_i,
  input  logic [7:0]  cpu_data_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_busy_o,
  output logic [15:0] mem_addr_o,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_data_o,
  input  logic [7:0]  mem_data_i,
  output logic        wp_err_o,
  output logic        ovf_err_o
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          oe_q, oe_d, we_q, we_d;
  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic          pend_wr_q, pend_wr_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  logic          cur_wr_q, cur_wr_d;
  logic          cur_sup_q, cur_sup_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] cpu_data_q, cpu_data_d;
  logic          busy_q, busy_d;
  logic          wp_err_q, wp_err_d;
  logic          ovf_err_q, ovf_err_d;

  logic          req_rd, req_wr, req, complete;
  logic          load_new, load_pend, to_slot;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_wr, ld_sup;

  // Strobe edge detection; a simultaneous write wins over the read
  always_comb begin
    req_rd   = cpu_oe_i & ~oe_q;
    req_wr   = cpu_we_i & ~we_q;
    req      = req_rd | req_wr;
    complete = (state_q == S_ACCESS) && (cnt_q == CW'(0));
  end

  // Next-state, pending slot, and registered output values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    oe_d         = cpu_oe_i;
    we_d         = cpu_we_i;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_wr_d    = pend_wr_q;
    pend_data_d  = pend_data_q;
    cur_wr_d     = cur_wr_q;
    cur_sup_d    = cur_sup_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    cpu_data_d   = cpu_data_q;
    wp_err_d     = wp_err_q;
    ovf_err_d    = ovf_err_q;
    mem_cs_d     = 1'b0;
    mem_we_d     = 1'b0;
    busy_d       = 1'b0;
    load_new     = 1'b0;
    load_pend    = 1'b0;
    to_slot      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) load_new = 1'b1;
      end
      S_ACCESS: begin
        if (complete) begin
          if (!cur_wr_q) begin
            if (cur_sup_q) cpu_data_d = mem_addr_q[0] ? RESET_VEC[7:0] : RESET_VEC[15:8];
            else           cpu_data_d = mem_data_i;
          end
          if (pend_valid_q) begin
            load_pend = 1'b1;
            if (req) to_slot = 1'b1;
            else     pend_valid_d = 1'b0;
          end else if (req) begin
            load_new = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (req) begin
            if (pend_valid_q) ovf_err_d = 1'b1;
            else              to_slot   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (to_slot) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = cpu_addr_i;
      pend_wr_d    = req_wr;
      pend_data_d  = cpu_data_i;
    end

    ld_addr = load_pend ? pend_addr_q : cpu_addr_i;
    ld_data = load_pend ? pend_data_q : cpu_data_i;
    ld_wr   = load_pend ? pend_wr_q   : req_wr;
    ld_sup  = ld_wr ? (ld_addr >= VEC_BASE) : (ld_addr[AW-1:1] == 15'h7FFF);

    if (load_new || load_pend) begin
      state_d    = S_ACCESS;
      cnt_d      = CW'(WAIT_STATES);
      mem_addr_d = ld_addr;
      mem_data_d = ld_data;
      cur_wr_d   = ld_wr;
      cur_sup_d  = ld_sup;
      if (ld_wr && ld_sup) wp_err_d = 1'b1;
    end

    mem_cs_d = (state_d == S_ACCESS) && !cur_sup_d;
    mem_we_d = mem_cs_d && cur_wr_d && (cnt_d == CW'(0));
    busy_d   = (state_d != S_IDLE) || pend_valid_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      oe_q         <= 1'b0;
      we_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_wr_q    <= 1'b0;
      pend_data_q  <= '0;
      cur_wr_q     <= 1'b0;
      cur_sup_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_data_q   <= '0;
      busy_q       <= 1'b0;
      wp_err_q     <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_wr_q    <= pend_wr_d;
      pend_data_q  <= pend_data_d;
      cur_wr_q     <= cur_wr_d;
      cur_sup_q    <= cur_sup_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      cpu_data_q   <= cpu_data_d;
      busy_q       <= busy_d;
      wp_err_q     <= wp_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // Write enable is also gated by reset so an aborted write never reaches RAM
  assign mem_we_o   = mem_we_q & ~cpu_reset;
  assign mem_cs_o   = mem_cs_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign cpu_data_o = cpu_data_q;
  assign cpu_busy_o = busy_q;
  assign wp_err_o   = wp_err_q;
  assign ovf_err_o  = ovf_err_q;

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Scoreboard bench for cpu_mem_ctrl: two instances (1 and 3 wait states),
// each with a synchronous RAM model; expectations are cycle-tagged entries
// consumed by an independent negedge monitor.
module tb_cpu_mem_ctrl;

  logic clk;
  int   cyc = 0;

  logic        rst0, oe0, we0, busy0, mcs0, mwe0, wp0, ovf0;
  logic [15:0] addr0, maddr0;
  logic [7:0]  di0, do0, mdo0, mdi0;
  logic        rst1, oe1, we1, busy1, mcs1, mwe1, wp1, ovf1;
  logic [15:0] addr1, maddr1;
  logic [7:0]  di1, do1, mdo1, mdi1;

  logic [7:0] ram0 [0:65535];
  logic [7:0] ram1 [0:65535];
  int wecnt0 = 0;

  cpu_mem_ctrl #(.WAIT_STATES(1)) u0 (
    .cpu_clk(clk), .cpu_reset(rst0), .cpu_addr_i(addr0), .cpu_oe_i(oe0),
    .cpu_we_i(we0), .cpu_data_i(di0), .cpu_data_o(do0), .cpu_busy_o(busy0),
    .mem_addr_o(maddr0), .mem_cs_o(mcs0), .mem_we_o(mwe0), .mem_data_o(mdo0),
    .mem_data_i(mdi0), .wp_err_o(wp0), .ovf_err_o(ovf0));

  cpu_mem_ctrl #(.WAIT_STATES(3)) u1 (
    .cpu_clk(clk), .cpu_reset(rst1), .cpu_addr_i(addr1), .cpu_oe_i(oe1),
    .cpu_we_i(we1), .cpu_data_i(di1), .cpu_data_o(do1), .cpu_busy_o(busy1),
    .mem_addr_o(maddr1), .mem_cs_o(mcs1), .mem_we_o(mwe1), .mem_data_o(mdo1),
    .mem_data_i(mdi1), .wp_err_o(wp1), .ovf_err_o(ovf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM models: read data valid the cycle after chip select
  always @(posedge clk) begin
    if (mwe0) wecnt0 <= wecnt0 + 1;
    if (mcs0 && mwe0) ram0[maddr0] <= mdo0;
    if (mcs0) mdi0 <= ram0[maddr0];
    if (mcs1 && mwe1) ram1[maddr1] <= mdo1;
    if (mcs1) mdi1 <= ram1[maddr1];
  end

  typedef struct {
    int          c;
    int          s;
    logic [15:0] v;
    string       nm;
  } chk_t;
  chk_t sbq[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [15:0] get_sig(int s);
    case (s)
      0:  return 16'(do0);
      1:  return 16'(busy0);
      2:  return 16'(mcs0);
      3:  return 16'(mwe0);
      4:  return maddr0;
      5:  return 16'(mdo0);
      6:  return 16'(wp0);
      7:  return 16'(ovf0);
      8:  return 16'(do1);
      9:  return 16'(busy1);
      10: return 16'(mcs1);
      11: return 16'(ovf1);
      12: return 16'(ram0[16'hFFF0]);
      13: return 16'(wecnt0);
      14: return 16'(ram0[16'h1234]);
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic expect_at(input int c, input int s, input logic [15:0] v, input string nm);
    chk_t e;
    e.c = c; e.s = s; e.v = v; e.nm = nm;
    sbq.push_back(e);
  endtask

  // Monitor: compares every scoreboard entry due in the current cycle
  always @(negedge clk) begin
    logic [15:0] got;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].c == cyc) begin
        got = get_sig(sbq[i].s);
        n_total++;
        if (got === sbq[i].v) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", sbq[i].nm, cyc, got, sbq[i].v);
        sbq.delete(i);
      end else if (sbq[i].c < cyc) begin
        n_total++;
        $display("FAIL %s: expectation for cyc %0d expired", sbq[i].nm, sbq[i].c);
        sbq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    int n;
    ram0[16'h1000] = 8'h8E;
    ram0[16'hFFF0] = 8'h77;
    ram0[16'h1234] = 8'h11;
    ram1[16'h2000] = 8'hA1;
    ram1[16'h2001] = 8'hB2;
    ram1[16'h2002] = 8'hC3;
    ram1[16'h2003] = 8'hD4;
    {oe0, we0, oe1, we1} = '0;
    addr0 = '0; addr1 = '0; di0 = '0; di1 = '0;
    rst0 = 1'b1; rst1 = 1'b1;
    ticks(2);
    rst0 = 1'b0; rst1 = 1'b0;
    n = cyc;
    expect_at(n, 0, 16'h00, "rst_cpu_data0");
    expect_at(n, 1, 16'h0, "rst_busy0");
    expect_at(n, 2, 16'h0, "rst_cs0");
    expect_at(n, 4, 16'h0000, "rst_maddr0");
    expect_at(n, 6, 16'h0, "rst_wp0");
    expect_at(n, 7, 16'h0, "rst_ovf0");
    expect_at(n, 8, 16'h00, "rst_cpu_data1");
    tick();

    // Read 1000 with one wait state
    n = cyc; addr0 = 16'h1000; oe0 = 1'b1;
    expect_at(n,     2, 16'h0, "rd_cs_before");
    expect_at(n + 1, 2, 16'h1, "rd_cs_c1");
    expect_at(n + 2, 2, 16'h1, "rd_cs_c2");
    expect_at(n + 3, 2, 16'h0, "rd_cs_after");
    expect_at(n + 1, 1, 16'h1, "rd_busy");
    expect_at(n + 2, 0, 16'h00, "rd_data_early");
    expect_at(n + 3, 0, 16'h8E, "rd_data");
    expect_at(n + 3, 1, 16'h0, "rd_busy_after");
    tick(); oe0 = 1'b0; ticks(4);

    // Write 5A to 0102, then read it back
    n = cyc; addr0 = 16'h0102; di0 = 8'h5A; we0 = 1'b1;
    expect_at(n + 1, 3, 16'h0, "wr_we_c1");
    expect_at(n + 2, 3, 16'h1, "wr_we_c2");
    expect_at(n + 3, 3, 16'h0, "wr_we_after");
    expect_at(n + 2, 4, 16'h0102, "wr_addr");
    expect_at(n + 2, 5, 16'h005A, "wr_data");
    expect_at(n + 3, 0, 16'h8E, "wr_keeps_cpu_data");
    tick(); we0 = 1'b0; ticks(4);
    n = cyc; oe0 = 1'b1;
    expect_at(n + 3, 0, 16'h5A, "rd_back");
    tick(); oe0 = 1'b0; ticks(4);

    // Reset-vector overlay reads
    n = cyc; addr0 = 16'hFFFE; oe0 = 1'b1;
    expect_at(n + 1, 2, 16'h0, "vec_cs_c1");
    expect_at(n + 2, 2, 16'h0, "vec_cs_c2");
    expect_at(n + 1, 1, 16'h1, "vec_busy");
    expect_at(n + 3, 0, 16'h10, "vec_hi");
    tick(); oe0 = 1'b0; ticks(4);
    n = cyc; addr0 = 16'hFFFF; oe0 = 1'b1;
    expect_at(n + 1, 2, 16'h0, "vec_lo_cs");
    expect_at(n + 3, 0, 16'h00, "vec_lo");
    tick(); oe0 = 1'b0; ticks(4);

    // Write to the protected vector page
    n = cyc; addr0 = 16'hFFF0; di0 = 8'h20; we0 = 1'b1;
    expect_at(n,     6, 16'h0, "wp_before");
    expect_at(n + 1, 2, 16'h0, "wp_cs");
    expect_at(n + 2, 3, 16'h0, "wp_we");
    expect_at(n + 2, 1, 16'h1, "wp_busy");
    expect_at(n + 3, 6, 16'h1, "wp_set");
    tick(); we0 = 1'b0; ticks(4);
    n = cyc;
    expect_at(n, 6, 16'h1, "wp_sticky");
    expect_at(n, 12, 16'h0077, "wp_ram_kept");
    expect_at(n, 13, 16'd1, "we_pulse_count");
    expect_at(n, 0, 16'h00, "wp_keeps_cpu_data");
    tick();

    // Reset during the first access cycle of a write; read strobe held through release
    n = cyc; addr0 = 16'h1234; di0 = 8'h99; we0 = 1'b1;
    tick();
    we0 = 1'b0; rst0 = 1'b1; oe0 = 1'b1; addr0 = 16'h1000;
    tick();
    rst0 = 1'b0;
    expect_at(n + 2, 2, 16'h0, "abort_cs");
    expect_at(n + 2, 3, 16'h0, "abort_we");
    expect_at(n + 2, 1, 16'h0, "abort_busy");
    expect_at(n + 2, 0, 16'h00, "abort_cpu_data");
    expect_at(n + 2, 6, 16'h0, "abort_wp_clear");
    expect_at(n + 2, 4, 16'h0000, "abort_maddr");
    expect_at(n + 2, 5, 16'h0000, "abort_mdata");
    expect_at(n + 3, 1, 16'h1, "held_rd_busy");
    expect_at(n + 5, 0, 16'h8E, "held_rd_data");
    expect_at(n + 5, 1, 16'h0, "held_rd_done");
    expect_at(n + 8, 1, 16'h0, "held_rd_once");
    expect_at(n + 5, 14, 16'h0011, "abort_ram_kept");
    expect_at(n + 5, 13, 16'd1, "abort_no_we");
    ticks(9); oe0 = 1'b0; ticks(2);

    // Three wait states: overlapping reads, slot refill on completion, overflow drop
    n = cyc; addr1 = 16'h2000; oe1 = 1'b1;
    expect_at(n + 5,  8, 16'hA1, "ovl_a");
    expect_at(n + 9,  8, 16'hB2, "ovl_b");
    expect_at(n + 13, 8, 16'hC3, "ovl_c");
    expect_at(n + 17, 8, 16'hC3, "ovl_d_dropped");
    expect_at(n + 5,  10, 16'h1, "ovl_no_gap");
    expect_at(n + 13, 10, 16'h0, "ovl_cs_end");
    expect_at(n + 6,  11, 16'h0, "ovl_ovf_before");
    expect_at(n + 7,  11, 16'h1, "ovl_ovf_set");
    expect_at(n + 12, 9, 16'h1, "ovl_busy_c");
    expect_at(n + 13, 9, 16'h0, "ovl_busy_end");
    expect_at(n + 16, 9, 16'h0, "ovl_idle");
    expect_at(n + 17, 11, 16'h1, "ovl_ovf_sticky");
    expect_at(n + 17, 7, 16'h0, "ovf0_clear");
    tick(); oe1 = 1'b0;
    tick(); oe1 = 1'b1; addr1 = 16'h2001;
    tick(); oe1 = 1'b0;
    tick(); oe1 = 1'b1; addr1 = 16'h2002;
    tick(); oe1 = 1'b0;
    tick(); oe1 = 1'b1; addr1 = 16'h2003;
    tick(); oe1 = 1'b0;

    for (int i = 0; i < 60 && sbq.size() > 0; i++) tick();
    if (sbq.size() > 0) begin
      n_total += sbq.size();
      $display("FAIL drain: %0d expectations never checked", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
